eth_hdr_capture_ctrl: RTL and testbench

Byte-serial Ethernet header sequencer for the 1G receive path. It consumes the post-SFD byte stream from the MAC byte interface and counts header bytes. It shifts destination MAC, source MAC, optional 802.1Q tag and EtherType into holding registers, then flags header completion and forwards payload bytes downstream. It is the control point that decides which bytes belong to the header delay/shift stages and which are payload.

---
 rtl/eth_hdr_capture_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_eth_hdr_capture_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_hdr_capture_ctrl.sv
// Byte-serial Ethernet header sequencer: captures DA/SA/optional 802.1Q tag/EtherType
// from the post-SFD byte stream and forwards the remaining bytes as payload.
module eth_hdr_capture_ctrl #(
  parameter bit          VLAN_EN       = 1'b1,
  parameter logic [15:0] TPID          = 16'h8100,
  parameter int          MIN_HDR_BYTES = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  input  logic        sof_i,
  input  logic        eof_i,
  output logic        hdr_valid_o,
  output logic [47:0] dst_mac_o,
  output logic [47:0] src_mac_o,
  output logic [15:0] ethertype_o,
  output logic        vlan_present_o,
  output logic [15:0] vlan_tci_o,
  output logic [7:0]  payload_byte_o,
  output logic        payload_valid_o,
  output logic        payload_eof_o,
  output logic        runt_o
);

  localparam logic [3:0] LAST_HDR_IDX = 4'(MIN_HDR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    TAG     = 3'd2,
    PAYLOAD = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [47:0] dst_sh_q, dst_sh_d;
  logic [47:0] src_sh_q, src_sh_d;
  logic [15:0] type_sh_q, type_sh_d;
  logic [15:0] tci_sh_q, tci_sh_d;
  logic        vlan_sh_q, vlan_sh_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [15:0] ethertype_q, ethertype_d;
  logic [15:0] vlan_tci_q, vlan_tci_d;
  logic        vlan_present_q, vlan_present_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        runt_q, runt_d;
  logic [7:0]  payload_byte_q, payload_byte_d;
  logic        payload_valid_q, payload_valid_d;
  logic        payload_eof_q, payload_eof_d;
  logic        complete_s;

  // Next-state, shadow-capture and output computation for one received byte
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    dst_sh_d        = dst_sh_q;
    src_sh_d        = src_sh_q;
    type_sh_d       = type_sh_q;
    tci_sh_d        = tci_sh_q;
    vlan_sh_d       = vlan_sh_q;
    dst_mac_d       = dst_mac_q;
    src_mac_d       = src_mac_q;
    ethertype_d     = ethertype_q;
    vlan_tci_d      = vlan_tci_q;
    vlan_present_d  = vlan_present_q;
    hdr_valid_d     = 1'b0;
    runt_d          = 1'b0;
    payload_byte_d  = payload_byte_q;
    payload_valid_d = 1'b0;
    payload_eof_d   = 1'b0;
    complete_s      = 1'b0;

    if (byte_valid_i && sof_i) begin
      // A payload byte is always on the outputs by the time the next sof is seen,
      // so a restart from PAYLOAD never needs a late payload_eof_o.
      runt_d    = eof_i || (state_q == HDR) || (state_q == TAG);
      dst_sh_d  = {dst_sh_q[39:0], byte_i};
      tci_sh_d  = 16'h0000;
      vlan_sh_d = 1'b0;
      if (eof_i) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end else begin
        state_d = HDR;
        cnt_d   = 4'd1;
      end
    end else if (byte_valid_i) begin
      case (state_q)
        HDR: begin
          if (cnt_q < 4'd6) begin
            dst_sh_d = {dst_sh_q[39:0], byte_i};
          end else if (cnt_q < 4'd12) begin
            src_sh_d = {src_sh_q[39:0], byte_i};
          end else begin
            type_sh_d = {type_sh_q[7:0], byte_i};
          end
          if (cnt_q == LAST_HDR_IDX) begin
            cnt_d = 4'd0;
            if (VLAN_EN && ({type_sh_q[7:0], byte_i} == TPID)) begin
              runt_d  = eof_i;
              state_d = eof_i ? IDLE : TAG;
            end else begin
              complete_s = 1'b1;
              state_d    = eof_i ? DRAIN : PAYLOAD;
            end
          end else if (eof_i) begin
            runt_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        TAG: begin
          vlan_sh_d = 1'b1;
          if (cnt_q < 4'd2) begin
            tci_sh_d = {tci_sh_q[7:0], byte_i};
          end else begin
            type_sh_d = {type_sh_q[7:0], byte_i};
          end
          if (cnt_q == 4'd3) begin
            complete_s = 1'b1;
            cnt_d      = 4'd0;
            state_d    = eof_i ? DRAIN : PAYLOAD;
          end else if (eof_i) begin
            runt_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        PAYLOAD: begin
          payload_byte_d  = byte_i;
          payload_valid_d = 1'b1;
          payload_eof_d   = eof_i;
          state_d         = eof_i ? IDLE : PAYLOAD;
        end
        // IDLE and DRAIN (header ended on the frame's last byte) drop stray bytes
        IDLE, DRAIN: state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    if (complete_s) begin
      hdr_valid_d    = 1'b1;
      dst_mac_d      = dst_sh_d;
      src_mac_d      = src_sh_d;
      ethertype_d    = type_sh_d;
      vlan_tci_d     = tci_sh_d;
      vlan_present_d = vlan_sh_d;
    end else begin
      hdr_valid_d = 1'b0;
    end
  end

  // State, shadow and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      dst_sh_q        <= 48'h0;
      src_sh_q        <= 48'h0;
      type_sh_q       <= 16'h0;
      tci_sh_q        <= 16'h0;
      vlan_sh_q       <= 1'b0;
      dst_mac_q       <= 48'h0;
      src_mac_q       <= 48'h0;
      ethertype_q     <= 16'h0;
      vlan_tci_q      <= 16'h0;
      vlan_present_q  <= 1'b0;
      hdr_valid_q     <= 1'b0;
      runt_q          <= 1'b0;
      payload_byte_q  <= 8'h00;
      payload_valid_q <= 1'b0;
      payload_eof_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dst_sh_q        <= dst_sh_d;
      src_sh_q        <= src_sh_d;
      type_sh_q       <= type_sh_d;
      tci_sh_q        <= tci_sh_d;
      vlan_sh_q       <= vlan_sh_d;
      dst_mac_q       <= dst_mac_d;
      src_mac_q       <= src_mac_d;
      ethertype_q     <= ethertype_d;
      vlan_tci_q      <= vlan_tci_d;
      vlan_present_q  <= vlan_present_d;
      hdr_valid_q     <= hdr_valid_d;
      runt_q          <= runt_d;
      payload_byte_q  <= payload_byte_d;
      payload_valid_q <= payload_valid_d;
      payload_eof_q   <= payload_eof_d;
    end
  end

  assign hdr_valid_o     = hdr_valid_q;
  assign dst_mac_o       = dst_mac_q;
  assign src_mac_o       = src_mac_q;
  assign ethertype_o     = ethertype_q;
  assign vlan_present_o  = vlan_present_q;
  assign vlan_tci_o      = vlan_tci_q;
  assign payload_byte_o  = payload_byte_q;
  assign payload_valid_o = payload_valid_q;
  assign payload_eof_o   = payload_eof_q;
  assign runt_o          = runt_q;

endmodule

// File: tb/tb_eth_hdr_capture_ctrl.sv
// Table-driven bench: one instance with tag recognition, one without, fed the same stream.
module tb_eth_hdr_capture_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        sof_i;
  logic        eof_i;

  logic        hv_v, vp_v, pv_v, pe_v, rt_v;
  logic [47:0] da_v, sa_v;
  logic [15:0] et_v, tci_v;
  logic [7:0]  pb_v;
  logic        hv_n, vp_n, pv_n, pe_n, rt_n;
  logic [47:0] da_n, sa_n;
  logic [15:0] et_n, tci_n;
  logic [7:0]  pb_n;

  eth_hdr_capture_ctrl #(.VLAN_EN(1'b1)) dut_v (
    .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .sof_i(sof_i), .eof_i(eof_i), .hdr_valid_o(hv_v), .dst_mac_o(da_v),
    .src_mac_o(sa_v), .ethertype_o(et_v), .vlan_present_o(vp_v),
    .vlan_tci_o(tci_v), .payload_byte_o(pb_v), .payload_valid_o(pv_v),
    .payload_eof_o(pe_v), .runt_o(rt_v)
  );

  eth_hdr_capture_ctrl #(.VLAN_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .sof_i(sof_i), .eof_i(eof_i), .hdr_valid_o(hv_n), .dst_mac_o(da_n),
    .src_mac_o(sa_n), .ethertype_o(et_n), .vlan_present_o(vp_n),
    .vlan_tci_o(tci_n), .payload_byte_o(pb_n), .payload_valid_o(pv_n),
    .payload_eof_o(pe_n), .runt_o(rt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-output code: {hdr_valid, runt, payload_valid, payload_eof, payload_byte}
  localparam logic [11:0] NONE = 12'h000;
  localparam logic [11:0] HV   = 12'h800;
  localparam logic [11:0] RT   = 12'h400;

  typedef struct {
    logic       rst;
    logic       vld;
    logic       sof;
    logic       eof;
    logic [7:0] b;
    logic [11:0] exp_v;
    logic [11:0] exp_n;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   gap      = 1'b0;

  function automatic logic [11:0] pv(input logic [7:0] b);
    return {4'b0010, b};
  endfunction

  function automatic logic [11:0] pve(input logic [7:0] b);
    return {4'b0011, b};
  endfunction

  function automatic logic [11:0] obs(input logic hv, input logic rt, input logic p,
                                      input logic pe, input logic [7:0] pb,
                                      input logic [11:0] e);
    return {hv, rt, p, pe, (e[9] ? pb : 8'h00)};
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic v, input logic s, input logic e,
                      input logic [7:0] b, input logic [11:0] ev, input logic [11:0] en);
    vec_t t;
    t.rst = r; t.vld = v; t.sof = s; t.eof = e; t.b = b; t.exp_v = ev; t.exp_n = en;
    tbl.push_back(t);
    if (gap && v) begin
      t.rst = 1'b0; t.vld = 1'b0; t.sof = 1'b0; t.eof = 1'b0; t.b = 8'h5A;
      t.exp_v = NONE; t.exp_n = NONE;
      tbl.push_back(t);
    end
  endtask

  task automatic push_hdr(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] et,
                          input logic eof13, input logic [11:0] e0,
                          input logic [11:0] e13v, input logic [11:0] e13n);
    logic [111:0] h;
    h = {da, sa, et};
    for (int i = 0; i < 14; i++) begin
      if (i == 0)       push(1'b0, 1'b1, 1'b1, 1'b0, h[111 -: 8], e0, e0);
      else if (i == 13) push(1'b0, 1'b1, 1'b0, eof13, h[111-8*i -: 8], e13v, e13n);
      else              push(1'b0, 1'b1, 1'b0, 1'b0, h[111-8*i -: 8], NONE, NONE);
    end
  endtask

  task automatic idle();
    push(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, NONE, NONE);
  endtask

  task automatic run_table(input string seg);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; byte_valid_i = tbl[i].vld; sof_i = tbl[i].sof;
      eof_i = tbl[i].eof; byte_i = tbl[i].b;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].vlan_en1", seg, i),
          {36'h0, obs(hv_v, rt_v, pv_v, pe_v, pb_v, tbl[i].exp_v)}, {36'h0, tbl[i].exp_v});
      chk($sformatf("%s[%0d].vlan_en0", seg, i),
          {36'h0, obs(hv_n, rt_n, pv_n, pe_n, pb_n, tbl[i].exp_n)}, {36'h0, tbl[i].exp_n});
    end
    rst = 1'b0; byte_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; byte_i = 8'h00;
    tbl.delete();
  endtask

  task automatic chk_v(input string nm, input logic [47:0] da, input logic [47:0] sa,
                       input logic [15:0] et, input logic vp, input logic [15:0] tci);
    chk({nm, ".v.dst"}, da_v, da);
    chk({nm, ".v.src"}, sa_v, sa);
    chk({nm, ".v.type"}, {32'h0, et_v}, {32'h0, et});
    chk({nm, ".v.vlan"}, {47'h0, vp_v}, {47'h0, vp});
    chk({nm, ".v.tci"}, {32'h0, tci_v}, {32'h0, tci});
  endtask

  task automatic chk_n(input string nm, input logic [47:0] da, input logic [15:0] et,
                       input logic vp, input logic [15:0] tci);
    chk({nm, ".n.dst"}, da_n, da);
    chk({nm, ".n.type"}, {32'h0, et_n}, {32'h0, et});
    chk({nm, ".n.vlan"}, {47'h0, vp_n}, {47'h0, vp});
    chk({nm, ".n.tci"}, {32'h0, tci_n}, {32'h0, tci});
  endtask

  initial begin
    rst = 1'b1; byte_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; byte_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ctrl_v", {36'h0, hv_v, rt_v, pv_v, pe_v, pb_v}, 48'h0);
    chk("reset.ctrl_n", {36'h0, hv_n, rt_n, pv_n, pe_n, pb_n}, 48'h0);
    chk_v("reset", 48'h0, 48'h0, 16'h0, 1'b0, 16'h0);
    rst = 1'b0;

    // Untagged frame with four payload bytes
    push_hdr(48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 1'b0, NONE, HV, HV);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, pv(8'hAA), pv(8'hAA));
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hBB, pv(8'hBB), pv(8'hBB));
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hCC, pv(8'hCC), pv(8'hCC));
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'hDD, pve(8'hDD), pve(8'hDD));
    idle();
    run_table("untagged");
    chk_v("untagged", 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 1'b0, 16'h0);
    chk_n("untagged", 48'h010203040506, 16'h0800, 1'b0, 16'h0);

    // 10-byte runt, sof+eof single byte, stray byte in IDLE
    for (int i = 0; i < 10; i++)
      push(1'b0, 1'b1, (i == 0), (i == 9), 8'(8'h50 + i), (i == 9) ? RT : NONE, (i == 9) ? RT : NONE);
    idle();
    push(1'b0, 1'b1, 1'b1, 1'b1, 8'h77, RT, RT);
    idle();
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'h66, NONE, NONE);
    idle();
    run_table("runt");
    chk_v("runt_hold", 48'h010203040506, 48'h0A0B0C0D0E0F, 16'h0800, 1'b0, 16'h0);

    // Tagged frame: TCI 0x6064, inner type 0x86DD
    push_hdr(48'h212223242526, 48'h313233343536, 16'h8100, 1'b0, NONE, NONE, HV);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h60, NONE, pv(8'h60));
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h64, NONE, pv(8'h64));
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h86, NONE, pv(8'h86));
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hDD, HV, pv(8'hDD));
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, pv(8'h11), pv(8'h11));
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'h22, pve(8'h22), pve(8'h22));
    idle();
    run_table("tagged");
    chk_v("tagged", 48'h212223242526, 48'h313233343536, 16'h86DD, 1'b1, 16'h6064);
    chk_n("tagged", 48'h212223242526, 16'h8100, 1'b0, 16'h0);

    // Tagged frame ending inside the tag
    push_hdr(48'h717273747576, 48'h313233343536, 16'h8100, 1'b0, NONE, NONE, HV);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h12, NONE, pv(8'h12));
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'h34, RT, pve(8'h34));
    idle();
    run_table("tag_runt");
    chk_v("tag_runt", 48'h212223242526, 48'h313233343536, 16'h86DD, 1'b1, 16'h6064);
    chk_n("tag_runt", 48'h717273747576, 16'h8100, 1'b0, 16'h0);

    // sof at header byte 7, back-to-back then with idle gaps
    for (int pass = 0; pass < 2; pass++) begin
      gap = (pass == 1);
      for (int i = 0; i < 7; i++)
        push(1'b0, 1'b1, (i == 0), 1'b0, 8'(8'h70 + i), NONE, NONE);
      push_hdr(pass == 0 ? 48'h414243444546 : 48'h818283848586, 48'h515253545556,
               16'h0806, 1'b0, RT, HV, HV);
      push(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, pv(8'h01), pv(8'h01));
      push(1'b0, 1'b1, 1'b0, 1'b1, 8'h02, pve(8'h02), pve(8'h02));
      idle();
      run_table(pass == 0 ? "restart" : "restart_gap");
      chk_v(pass == 0 ? "restart" : "restart_gap",
            pass == 0 ? 48'h414243444546 : 48'h818283848586, 48'h515253545556,
            16'h0806, 1'b0, 16'h0);
    end
    gap = 1'b0;

    // Header completes on the frame's last byte; then a stray byte is dropped
    push_hdr(48'h616263646566, 48'h0A0B0C0D0E0F, 16'h0800, 1'b1, NONE, HV, HV);
    idle();
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'h99, NONE, NONE);
    idle();
    run_table("eof13");
    chk_v("eof13", 48'h616263646566, 48'h0A0B0C0D0E0F, 16'h0800, 1'b0, 16'h0);

    // sof while in PAYLOAD: previous byte already emitted, no runt
    push_hdr(48'h010101010101, 48'h020202020202, 16'h0800, 1'b0, NONE, HV, HV);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hE1, pv(8'hE1), pv(8'hE1));
    push_hdr(48'h030303030303, 48'h040404040404, 16'h88B5, 1'b1, NONE, HV, HV);
    idle();
    run_table("sof_in_payload");
    chk_v("sof_in_payload", 48'h030303030303, 48'h040404040404, 16'h88B5, 1'b0, 16'h0);

    // Reset at payload byte 2 clears everything silently
    push_hdr(48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 16'h0800, 1'b0, NONE, HV, HV);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hC1, pv(8'hC1), pv(8'hC1));
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hC2, pv(8'hC2), pv(8'hC2));
    push(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, NONE, NONE);
    run_table("reset_mid");
    chk_v("reset_mid", 48'h0, 48'h0, 16'h0, 1'b0, 16'h0);
    chk_n("reset_mid", 48'h0, 16'h0, 1'b0, 16'h0);
    chk("reset_mid.pb", {40'h0, pb_v}, 48'h0);

    push_hdr(48'hD1D2D3D4D5D6, 48'hE1E2E3E4E5E6, 16'h0800, 1'b0, NONE, HV, HV);
    push(1'b0, 1'b1, 1'b0, 1'b0, 8'hF1, pv(8'hF1), pv(8'hF1));
    push(1'b0, 1'b1, 1'b0, 1'b1, 8'hF2, pve(8'hF2), pve(8'hF2));
    idle();
    run_table("after_reset");
    chk_v("after_reset", 48'hD1D2D3D4D5D6, 48'hE1E2E3E4E5E6, 16'h0800, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
